// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, redirect input and decode handshake.
// master = fetch unit, slave = the surrounding core/memory/decode.
interface inst_fetch_unit_if #(
    parameter int unsigned IMEM_W = 13
);
    logic [IMEM_W-1:0] imem_addr_o;
    logic [31:0]       imem_rdata_i;
    logic              redirect_valid_i;
    logic [31:0]       redirect_pc_i;
    logic              inst_valid_o;
    logic              inst_ready_i;
    logic [31:0]       inst_o;
    logic [31:0]       pc_o;
    logic              fault_o;
    logic [31:0]       fault_pc_o;

    modport master (
        output imem_addr_o,
        output inst_valid_o,
        output inst_o,
        output pc_o,
        output fault_o,
        output fault_pc_o,
        input  imem_rdata_i,
        input  redirect_valid_i,
        input  redirect_pc_i,
        input  inst_ready_i
    );

    modport slave (
        input  imem_addr_o,
        input  inst_valid_o,
        input  inst_o,
        input  pc_o,
        input  fault_o,
        input  fault_pc_o,
        output imem_rdata_i,
        output redirect_valid_i,
        output redirect_pc_i,
        output inst_ready_i
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches from a combinational instruction memory into a
// 2-entry queue, and hands entries to decode over valid/ready with redirect and fault handling.
module inst_fetch_unit #(
    parameter int unsigned IMEM_W   = 13,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    inst_fetch_unit_if.master bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_fault_pc, w_fault_pc_nxt;
    logic [1:0]  r_count, w_count_nxt;
    logic        r_head, w_head_nxt;
    logic [31:0] r_q_pc   [2];
    logic [31:0] r_q_inst [2];

    logic w_pop;
    logic w_room;
    logic w_in_range;
    logic w_fetch;
    logic w_oor_fault;
    logic w_redir_misaligned;
    logic w_redir_in_range;
    logic w_tail;

    always_comb begin
        w_pop              = (r_count != 2'd0) & bus.inst_ready_i;
        w_room             = (r_count != 2'd2) | w_pop;
        w_in_range         = (r_pc[31:IMEM_W] == '0);
        w_fetch            = (r_state == S_RUN) & ~bus.redirect_valid_i & w_room & w_in_range;
        w_oor_fault        = (r_state == S_RUN) & ~bus.redirect_valid_i & w_room & ~w_in_range;
        w_redir_misaligned = (bus.redirect_pc_i[1:0] != 2'b00);
        w_redir_in_range   = (bus.redirect_pc_i[31:IMEM_W] == '0);
        // Tail slot is head + count (mod 2); with count=2 it reuses the slot being popped.
        w_tail             = r_head ^ r_count[0];
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_fault_pc_nxt = r_fault_pc;
        w_count_nxt    = r_count;
        w_head_nxt     = r_head;

        if (bus.redirect_valid_i) begin
            w_pc_nxt    = bus.redirect_pc_i;
            w_count_nxt = 2'd0;
            if (w_redir_misaligned || ((r_state == S_FAULT) && !w_redir_in_range)) begin
                w_state_nxt    = S_FAULT;
                w_fault_pc_nxt = bus.redirect_pc_i;
            end else begin
                w_state_nxt = S_RUN;
            end
        end else begin
            case (r_state)
                S_BOOT:  w_state_nxt = S_RUN;
                S_RUN: begin
                    if (w_oor_fault) begin
                        w_state_nxt    = S_FAULT;
                        w_fault_pc_nxt = r_pc;
                    end
                end
                S_FAULT: w_state_nxt = S_FAULT;
                default: w_state_nxt = S_BOOT;
            endcase

            if (w_fetch) begin
                w_pc_nxt = r_pc + 32'd4;
            end
            if (w_pop) begin
                w_head_nxt = ~r_head;
            end
            w_count_nxt = r_count + {1'b0, w_fetch} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_fault_pc <= 32'd0;
            r_count    <= 2'd0;
            r_head     <= 1'b0;
            // NOTE: the queue storage is reset too, because its head is visible on inst_o/pc_o.
            for (int i = 0; i < 2; i++) begin
                r_q_pc[i]   <= 32'd0;
                r_q_inst[i] <= NOP;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_fault_pc <= w_fault_pc_nxt;
            r_count    <= w_count_nxt;
            r_head     <= w_head_nxt;
            if (w_fetch) begin
                r_q_pc[w_tail]   <= r_pc;
                r_q_inst[w_tail] <= bus.imem_rdata_i;
            end
        end
    end

    assign bus.imem_addr_o  = r_pc[IMEM_W-1:0];
    assign bus.inst_valid_o = (r_count != 2'd0);
    assign bus.inst_o       = r_q_inst[r_head];
    assign bus.pc_o         = r_q_pc[r_head];
    assign bus.fault_o      = (r_state == S_FAULT);
    assign bus.fault_pc_o   = r_fault_pc;
endmodule
